// File: rtl/mul_div_pkg.sv
// Shared types and constants for the sequential multiply/divide block.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateType;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

endpackage

// File: rtl/mul_div_step.sv
// One iteration of shift-add multiply or restoring divide.
// The accumulator is {upper[M:0], lower[N-1:0]}; the lower field holds the
// multiplier or dividend bits not yet consumed.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic           mode,
  input  logic [N+M:0]   accumulator,
  input  logic [M-1:0]   operand,
  output logic [N+M:0]   nextAccumulator
);

  logic [M:0]   upper;
  logic [M:0]   partial;
  logic [M:0]   sum;
  logic [M:0]   trial;
  logic [N+M:0] added;
  logic [N+M:0] shifted;

  always_comb begin
    upper   = accumulator[N+M:N];
    partial = accumulator[0] ? {1'b0, operand} : '0;
    sum     = upper + partial;
    added   = {sum, accumulator[N-1:0]};

    // Shifting left brings the next dividend MSB into the partial remainder.
    shifted = {accumulator[N+M-1:0], 1'b0};
    trial   = shifted[N+M:N] - {1'b0, operand};

    nextAccumulator = shifted;
    if (mode == MODE_MUL) begin
      nextAccumulator = added >> 1;
    end else if (shifted[N+M:N] >= {1'b0, operand}) begin
      nextAccumulator[N+M:N] = trial;
      nextAccumulator[0]     = 1'b1;
    end
  end

endmodule

// File: rtl/seq_mul_div.sv
// Sequential unsigned multiplier / restoring divider, one bit per cycle.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | iterating, down-counter holds remaining steps
// DONE  | Result valid, Done pulses for one cycle
module seq_mul_div
  import mul_div_pkg::*;
#(
  parameter int DEVIDENT_LENGTH = 5,
  parameter int DIVISOR_LENGTH  = 5
) (
  input  logic                                      Clk,
  input  logic                                      Rst,
  input  logic                                      Start,
  input  logic                                      Mode,
  input  logic [DEVIDENT_LENGTH-1:0]                OperX,
  input  logic [DIVISOR_LENGTH-1:0]                 OperY,
  output logic                                      Busy,
  output logic                                      Done,
  output logic [DEVIDENT_LENGTH+DIVISOR_LENGTH-1:0] Result,
  output logic                                      DivByZero
);

  localparam int N     = DEVIDENT_LENGTH;
  localparam int M     = DIVISOR_LENGTH;
  localparam int ACC_W = N + M + 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  stateType         state;
  logic             modeReg;
  logic [M-1:0]     operYReg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;
  logic [CNT_W-1:0] count;
  logic             divZero;

  assign divZero = (Mode == MODE_DIV) && (OperY == '0);

  mul_div_step #(
    .N (N),
    .M (M)
  ) uStep (
    .mode            (modeReg),
    .accumulator     (acc),
    .operand         (operYReg),
    .nextAccumulator (accNext)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Result    <= '0;
      DivByZero <= 1'b0;
      count     <= '0;
      acc       <= '0;
      modeReg   <= MODE_MUL;
      operYReg  <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (Start) begin
            if (divZero) begin
              state     <= DONE;
              Done      <= 1'b1;
              Result    <= {{M{1'b0}}, {N{1'b1}}};
              DivByZero <= 1'b1;
            end else begin
              state    <= RUN;
              Busy     <= 1'b1;
              modeReg  <= Mode;
              operYReg <= OperY;
              acc      <= {{(M+1){1'b0}}, OperX};
              count    <= CNT_LOAD;
            end
          end
        end
        RUN: begin
          acc   <= accNext;
          count <= count - CNT_TC;
          if (count == CNT_TC) begin
            state     <= DONE;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Result    <= accNext[N+M-1:0];
            DivByZero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed-vector bench for seq_mul_div with N = M = 5.
module tb_seq_mul_div;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Start;
  logic       Mode;
  logic [4:0] OperX;
  logic [4:0] OperY;
  logic       Busy;
  logic       Done;
  logic [9:0] Result;
  logic       DivByZero;

  int         errCnt = 0;
  int         chkCnt = 0;
  logic [9:0] lastRes = '0;

  seq_mul_div #(
    .DEVIDENT_LENGTH (5),
    .DIVISOR_LENGTH  (5)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Mode      (Mode),
    .OperX     (OperX),
    .OperY     (OperY),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result),
    .DivByZero (DivByZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Leaves the bench at the negedge of the 1st cycle after the Start edge.
  task automatic issueOp(input logic m, input logic [4:0] x, input logic [4:0] y);
    @(negedge Clk);
    Start = 1'b1;
    Mode  = m;
    OperX = x;
    OperY = y;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called at the negedge of cycle firstCycle; returns in the Done cycle.
  task automatic waitDone(input string tag, input int firstCycle, input int expLat,
                          input logic [9:0] expRes, input logic expDbz);
    int lat = 0;
    int busyErr = 0;
    int holdErr = 0;
    for (int c = firstCycle; c <= expLat + 4; c++) begin
      if (Done === 1'b1) begin
        lat = c;
        break;
      end
      if (Busy !== 1'b1) busyErr++;
      if (Result !== lastRes) holdErr++;
      @(negedge Clk);
    end
    checkVal({tag, "_latency"}, lat, expLat);
    checkVal({tag, "_result"}, {22'd0, Result}, {22'd0, expRes});
    checkVal({tag, "_dbz"}, {31'd0, DivByZero}, {31'd0, expDbz});
    checkVal({tag, "_busyAtDone"}, {31'd0, Busy}, 32'd0);
    checkVal({tag, "_busyRun"}, busyErr, 0);
    checkVal({tag, "_holdRun"}, holdErr, 0);
    lastRes = expRes;
  endtask

  task automatic checkAfterDone(input string tag);
    @(negedge Clk);
    checkVal({tag, "_donePulse"}, {31'd0, Done}, 32'd0);
    checkVal({tag, "_resHold"}, {22'd0, Result}, {22'd0, lastRes});
  endtask

  task automatic doOp(input string tag, input logic m, input logic [4:0] x, input logic [4:0] y,
                      input int expLat, input logic [9:0] expRes, input logic expDbz);
    issueOp(m, x, y);
    waitDone(tag, 1, expLat, expRes, expDbz);
    checkAfterDone(tag);
  endtask

  initial begin
    int doneSeen;
    Rst   = 1'b1;
    Start = 1'b1;
    Mode  = 1'b0;
    OperX = 5'd1;
    OperY = 5'd1;
    repeat (3) @(negedge Clk);
    checkVal("rstBusy", {31'd0, Busy}, 32'd0);
    checkVal("rstDone", {31'd0, Done}, 32'd0);
    checkVal("rstResult", {22'd0, Result}, 32'd0);
    checkVal("rstDbz", {31'd0, DivByZero}, 32'd0);
    Rst   = 1'b0;
    Start = 1'b0;
    @(negedge Clk);
    checkVal("idleBusy", {31'd0, Busy}, 32'd0);

    // {remainder, quotient} packs as remainder*32 + quotient.
    doOp("mul1x1",   1'b0, 5'd1,  5'd1,  6, 10'd1,   1'b0);
    doOp("mul31x31", 1'b0, 5'd31, 5'd31, 6, 10'd961, 1'b0);
    doOp("div2by5",  1'b1, 5'd2,  5'd5,  6, 10'd64,  1'b0);
    doOp("div31by7", 1'b1, 5'd31, 5'd7,  6, 10'd100, 1'b0);
    doOp("div9by0",  1'b1, 5'd9,  5'd0,  1, 10'd31,  1'b1);
    doOp("div13by3", 1'b1, 5'd13, 5'd3,  6, 10'd36,  1'b0);
    doOp("div31by1", 1'b1, 5'd31, 5'd1,  6, 10'd31,  1'b0);
    doOp("mul0x17",  1'b0, 5'd0,  5'd17, 6, 10'd0,   1'b0);

    // Second Start during RUN is ignored; Start during DONE relaunches at once.
    issueOp(1'b0, 5'd3, 5'd4);
    @(negedge Clk);
    Start = 1'b1;
    Mode  = 1'b1;
    OperX = 5'd7;
    OperY = 5'd7;
    @(negedge Clk);
    Start = 1'b0;
    waitDone("b2bFirst", 3, 6, 10'd12, 1'b0);
    Start = 1'b1;
    Mode  = 1'b0;
    OperX = 5'd6;
    OperY = 5'd7;
    @(negedge Clk);
    Start = 1'b0;
    checkVal("b2bNoIdle", {31'd0, Busy}, 32'd1);
    waitDone("b2bSecond", 1, 6, 10'd42, 1'b0);
    checkAfterDone("b2bSecond");

    // Reset in the 3rd RUN cycle aborts without a Done pulse.
    issueOp(1'b0, 5'd3, 5'd3);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkVal("abortBusy", {31'd0, Busy}, 32'd0);
    checkVal("abortResult", {22'd0, Result}, 32'd0);
    lastRes = '0;
    doneSeen = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done === 1'b1) doneSeen++;
      @(negedge Clk);
    end
    checkVal("abortNoDone", doneSeen, 0);
    doOp("mul6x5", 1'b0, 5'd6, 5'd5, 6, 10'd30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
